tx_interp_fir: RTL

Four-channel time-multiplexed polyphase interpolating FIR for the sonar transmit path. Takes one 24-bit sample per channel on AXI-Stream, with the channel in tuser, and emits INTERP filtered output samples per input toward the DAC chain. It is the transmit-side counterpart of the receive lowpass: it upsamples rather than filters at the input rate. A single shared multiplier–accumulator processes all phases, and coefficients are runtime-loadable.

---
 rtl/tx_interp_fir.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_interp_fir.sv
// Four-channel time-multiplexed polyphase interpolating FIR (transmit path).
// One input sample per channel produces INTERP output samples, each computed
// by a single shared multiply-accumulate over PT = TAPS/INTERP history taps.
module tx_interp_fir #(
  parameter int unsigned INTERP    = 4,
  parameter int unsigned TAPS      = 64,
  parameter int unsigned OUT_SHIFT = 23
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arst,
  input  logic [23:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [1:0]               s_axis_tuser,
  output logic [23:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [1:0]               m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     coe_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coe_wr_addr,
  input  logic [23:0]              coe_wr_data,
  output logic                     coe_wr_ready
);

  localparam int unsigned NCH = 4;
  localparam int unsigned PT  = TAPS / INTERP;
  localparam int unsigned PW  = $clog2(PT);
  localparam int unsigned PHW = $clog2(INTERP);
  localparam int unsigned AW  = $clog2(TAPS);
  localparam int unsigned HW  = $clog2(NCH * PT);
  localparam int unsigned CW  = $clog2(PT + 2);

  localparam logic [HW-1:0]  CLR_LAST  = HW'(NCH * PT - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(PT + 1);
  localparam logic [CW-1:0]  CNT_ACC0  = CW'(2);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(INTERP - 1);

  localparam logic signed [47:0] ACC_MAX = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [47:0] ACC_MIN = 48'sh8000_0000_0000;
  localparam logic signed [48:0] RND     = 49'sd1 <<< (OUT_SHIFT - 1);
  localparam logic signed [48:0] OUT_MAX = 49'sd8388607;
  localparam logic signed [48:0] OUT_MIN = -49'sd8388608;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]  clr_cnt;
  logic [CW-1:0]  cnt;
  logic [PHW-1:0] phase;
  logic [1:0]     ch;
  logic [PW-1:0]  wptr [NCH];

  logic signed [23:0] hist [NCH*PT];
  logic signed [23:0] coef [TAPS];

  logic signed [23:0] rd_x;
  logic signed [23:0] rd_h;
  logic signed [47:0] prod;
  logic signed [47:0] acc;

  logic               in_hs;
  logic               out_hs;
  logic               coe_we;
  logic               mac_last;

  logic               hist_we;
  logic [HW-1:0]      hist_waddr;
  logic signed [23:0] hist_wdata;
  logic [HW-1:0]      hist_raddr;
  logic [AW-1:0]      coef_raddr;
  logic [PW-1:0]      rd_off;

  logic signed [48:0] acc_sum;
  logic signed [47:0] acc_nxt;
  logic signed [48:0] rnd_sum;
  logic signed [48:0] shifted;
  logic signed [23:0] out_sat;

  assign in_hs    = s_axis_tvalid & s_axis_tready;
  assign out_hs   = m_axis_tvalid & m_axis_tready;
  assign coe_we   = coe_wr_en & coe_wr_ready;
  assign mac_last = (state == ST_MAC) && (cnt == CNT_LAST);

  // State register; reset always restarts the history clear.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) state <= ST_CLEAR;
    else             state <= state_nxt;
  end

  // Next-state logic and the state-decoded ready outputs.
  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    coe_wr_ready  = 1'b0;
    case (state)
      ST_CLEAR: begin
        coe_wr_ready = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        s_axis_tready = 1'b1;
        coe_wr_ready  = 1'b1;
        if (s_axis_tvalid) state_nxt = ST_MAC;
      end
      ST_MAC: begin
        if (cnt == CNT_LAST) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_hs) state_nxt = (phase == PH_LAST) ? ST_IDLE : ST_MAC;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Control registers: clear sweep, per-channel write pointers, phase, channel.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      clr_cnt <= '0;
      phase   <= '0;
      ch      <= '0;
      for (int unsigned i = 0; i < NCH; i++) wptr[i] <= '0;
    end else begin
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (in_hs) begin
        ch                 <= s_axis_tuser;
        wptr[s_axis_tuser] <= wptr[s_axis_tuser] + 1'b1;
        phase              <= '0;
      end
      if (out_hs && (phase != PH_LAST)) phase <= phase + 1'b1;
    end
  end

  // MAC cycle counter: restarts at zero on every entry to MAC.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst)          cnt <= '0;
    else if (state == ST_MAC) cnt <= cnt + 1'b1;
    else                      cnt <= '0;
  end

  // Address generation: tap k = cnt reads x[n-k] and h[k*INTERP + p].
  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = clr_cnt;
    hist_wdata = '0;
    if (state == ST_CLEAR) begin
      hist_we = 1'b1;
    end else if (in_hs) begin
      hist_we    = 1'b1;
      hist_waddr = {s_axis_tuser, wptr[s_axis_tuser]};
      hist_wdata = s_axis_tdata;
    end
    rd_off     = wptr[ch] - PW'(1) - cnt[PW-1:0];
    hist_raddr = {ch, rd_off};
    coef_raddr = {cnt[PW-1:0], phase};
  end

  // History RAM with registered read port.
  always_ff @(posedge s_axis_aclk) begin
    if (hist_we) hist[hist_waddr] <= hist_wdata;
    rd_x <= hist[hist_raddr];
  end

  // Coefficient RAM with registered read port; not cleared by reset.
  always_ff @(posedge s_axis_aclk) begin
    if (coe_we) coef[coe_wr_addr] <= coe_wr_data;
    rd_h <= coef[coef_raddr];
  end

  // Accumulate saturates rather than wraps so that full-scale inputs on
  // full-scale taps clamp cleanly instead of folding back through zero.
  always_comb begin
    acc_sum = {acc[47], acc} + {prod[47], prod};
    if (acc_sum[48] != acc_sum[47]) acc_nxt = acc_sum[48] ? ACC_MIN : ACC_MAX;
    else                            acc_nxt = acc_sum[47:0];
    rnd_sum = {acc_nxt[47], acc_nxt} + RND;
    shifted = rnd_sum >>> OUT_SHIFT;
    if (shifted > OUT_MAX)      out_sat = 24'sh7FFFFF;
    else if (shifted < OUT_MIN) out_sat = 24'sh800000;
    else                        out_sat = shifted[23:0];
  end

  // Multiply stage, then accumulate; products land from cnt=2 to cnt=PT+1.
  always_ff @(posedge s_axis_aclk) begin
    prod <= rd_x * rd_h;
    if (state == ST_MAC) acc <= (cnt >= CNT_ACC0) ? acc_nxt : '0;
  end

  // Output register: loaded on the final accumulate, held until accepted.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (mac_last) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_sat;
      m_axis_tuser  <= ch;
      m_axis_tlast  <= (phase == PH_LAST);
    end else if (out_hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
